// File: rtl/timer_pkg.sv
// Shared definitions for the down-counter interval timer: default width and FSM states.
package timer_pkg;

  // Default counter / load-value width in bits.
  localparam int DEFAULT_WIDTH = 3;

  // Control FSM states with fixed encodings.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/down_count_core.sv
// Datapath of the down-counter timer: count and reload registers, decrement,
// reload mux and the zero/one detectors the control FSM steers by.
module down_count_core
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             dec_i,
  input  logic             rl_i,
  output logic [WIDTH-1:0] count_o,
  output logic             is_zero_o,
  output logic             is_one_o,
  output logic             reload_zero_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;

  // Next count: load wins over reload, reload over decrement; decrement saturates at zero.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (ld_i) begin
      count_d  = ld_val_i;
      reload_d = ld_val_i;
    end else if (rl_i) begin
      count_d = reload_q;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count and reload registers, cleared immediately by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count_o       = count_q;
  assign is_zero_o     = (count_q == '0);
  assign is_one_o      = (count_q == WIDTH'(1));
  assign reload_zero_o = (reload_q == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Programmable interval timer: loadable down-counter with optional auto-reload,
// driven by an IDLE/RUN/HOLD control FSM, with a registered terminal-count pulse.
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             tc_q, tc_d;
  logic             busy_q;
  logic             ld, dec, rl;
  logic             isZero, isOne, reloadZero;
  logic [WIDTH-1:0] nextCount;

  down_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i        (clk),
    .rst_ni       (reset),
    .ld_i         (ld),
    .ld_val_i     (load_val),
    .dec_i        (dec),
    .rl_i         (rl),
    .count_o      (count),
    .is_zero_o    (isZero),
    .is_one_o     (isOne),
    .reload_zero_o(reloadZero)
  );

  // The value the counter will hold after this edge if nothing but load acts on it.
  assign nextCount = load ? load_val : count;

  // Resolve abort > load > pause > start > count into next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    ld      = load;
    dec     = 1'b0;
    rl      = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (nextCount != '0)) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (!load) begin
            if (isOne) begin
              dec     = 1'b1;
              tc_d    = 1'b1;
              state_d = (auto_reload && !reloadZero) ? ST_RUN : ST_IDLE;
            end else if (isZero) begin
              rl = 1'b1;
            end else begin
              dec = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (start && !pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, terminal-count pulse and busy flag all update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign tc   = tc_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a table of directed vectors plus
// hand-written sequences for reset during reset-hold and mid-run.
`timescale 1ns/1ps
module tb_down_counter_timer;

  typedef struct {
    logic       load;
    logic [2:0] loadVal;
    logic       start;
    logic       pause;
    logic       abort;
    logic       autoReload;
    logic [2:0] expCount;
    logic       expTc;
    logic       expBusy;
  } vecT;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [2:0] loadVal;
  logic       start;
  logic       pause;
  logic       abort;
  logic       autoReload;
  logic [2:0] count;
  logic       tc;
  logic       busy;

  int  assertCount = 0;
  int  failCount   = 0;
  vecT vecs[$];

  down_counter_timer #(
    .WIDTH(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_val   (loadVal),
    .start      (start),
    .pause      (pause),
    .abort      (abort),
    .auto_reload(autoReload),
    .count      (count),
    .tc         (tc),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Append one vector: inputs, then outputs expected after the next rising edge.
  task automatic addVec(input logic l, input logic [2:0] lv, input logic s, input logic p,
                        input logic a, input logic ar, input logic [2:0] ec,
                        input logic et, input logic eb);
    vecT v;
    v.load = l; v.loadVal = lv; v.start = s; v.pause = p; v.abort = a;
    v.autoReload = ar; v.expCount = ec; v.expTc = et; v.expBusy = eb;
    vecs.push_back(v);
  endtask

  // Drive all control inputs at once.
  task automatic applyStimulus(input logic l, input logic [2:0] lv, input logic s,
                               input logic p, input logic a, input logic ar);
    load = l; loadVal = lv; start = s; pause = p; abort = a; autoReload = ar;
  endtask

  // Compare the three outputs against expected values.
  task automatic checkOutput(input string name, input logic [2:0] expCount,
                             input logic expTc, input logic expBusy);
    assertCount++;
    if (count !== expCount) begin
      failCount++;
      $display("[TB] FAIL %s count: got %0d, expected %0d", name, count, expCount);
    end
    assertCount++;
    if (tc !== expTc) begin
      failCount++;
      $display("[TB] FAIL %s tc: got %b, expected %b", name, tc, expTc);
    end
    assertCount++;
    if (busy !== expBusy) begin
      failCount++;
      $display("[TB] FAIL %s busy: got %b, expected %b", name, busy, expBusy);
    end
  endtask

  // Step one clock and sample 1 ns after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // first edge after reset release keeps IDLE
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // one-shot from 5
    addVec(1, 5, 1, 0, 0, 0, 5, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 4, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 3, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // start with a zero next-count stays IDLE
    addVec(1, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0, 0, 0);
    // auto-reload from 7, period 8
    addVec(1, 7, 1, 0, 0, 1, 7, 0, 1);
    for (int k = 6; k >= 1; k--) addVec(0, 0, 0, 0, 0, 1, 3'(k), 0, 1);
    addVec(0, 0, 0, 0, 0, 1, 0, 1, 1);
    addVec(0, 0, 0, 0, 0, 1, 7, 0, 1);
    for (int k = 6; k >= 1; k--) addVec(0, 0, 0, 0, 0, 1, 3'(k), 0, 1);
    addVec(0, 0, 0, 0, 0, 1, 0, 1, 1);
    addVec(0, 0, 0, 0, 0, 1, 7, 0, 1);
    for (int k = 6; k >= 4; k--) addVec(0, 0, 0, 0, 0, 1, 3'(k), 0, 1);
    // clearing auto_reload ends the run at the next zero
    for (int k = 3; k >= 1; k--) addVec(0, 0, 0, 0, 0, 0, 3'(k), 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pause at 2 for three cycles, then resume
    addVec(1, 4, 1, 0, 0, 0, 4, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 3, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 2, 0, 1);
    addVec(0, 0, 1, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pause at count 1 raises no tc
    addVec(1, 2, 1, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 1, 0, 1);
    addVec(0, 0, 1, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // pause+start in HOLD stays HOLD; abort+load in RUN
    addVec(1, 3, 1, 0, 0, 0, 3, 0, 1);
    addVec(0, 0, 0, 1, 0, 0, 3, 0, 1);
    addVec(0, 0, 1, 1, 0, 0, 3, 0, 1);
    addVec(0, 0, 1, 0, 0, 0, 3, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 2, 0, 1);
    addVec(1, 6, 0, 0, 1, 0, 6, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 6, 0, 0);
    // load during RUN skips the decrement that cycle
    addVec(1, 5, 1, 0, 0, 0, 5, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 4, 0, 1);
    addVec(1, 2, 0, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);
    // abort at count 1 freezes the count with no tc
    addVec(1, 2, 1, 0, 0, 0, 2, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 1, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // start from a held nonzero count without load
    addVec(0, 0, 1, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset held for 12 ns with random inputs.
    reset = 1'b0;
    applyStimulus(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
    #6;
    applyStimulus(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
    #6;
    checkOutput("reset_hold", 3'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].load, vecs[i].loadVal, vecs[i].start, vecs[i].pause,
                    vecs[i].abort, vecs[i].autoReload);
      stepCycle();
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expTc, vecs[i].expBusy);
    end

    // Asynchronous reset in the middle of a run at count 3.
    applyStimulus(1, 5, 1, 0, 0, 0);
    stepCycle();
    checkOutput("mid_run_5", 3'd5, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("mid_run_4", 3'd4, 1'b0, 1'b1);
    stepCycle();
    checkOutput("mid_run_3", 3'd3, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_now", 3'd0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("async_reset_held", 3'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    stepCycle();
    checkOutput("after_release", 3'd0, 1'b0, 1'b0);

    $display("[TB] %0d vectors applied", vecs.size());
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
